// File: rtl/slice_column_renderer.sv
// Frame sequencer and column painter: requests a wall height per screen column from the
// slice calculator, then plots one ceiling/wall/floor column of pixels per clock.
module slice_column_renderer #(
    parameter int unsigned ScreenW     = 160,
    parameter int unsigned ScreenH     = 120,
    parameter int unsigned CalcTimeout = 255,
    parameter logic [2:0]  CeilColour  = 3'b001,
    parameter logic [2:0]  WallColour  = 3'b100,
    parameter logic [2:0]  FloorColour = 3'b010
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start_frame,
    input  logic [6:0] slice_size,
    input  logic       end_calc,
    output logic       begin_calc,
    output logic [7:0] column_count,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] LastCol    = 8'(ScreenW - 1);
    localparam logic [6:0] LastRow    = 7'(ScreenH - 1);
    localparam logic [6:0] MaxH       = 7'(ScreenH);
    localparam logic [7:0] TimeoutCnt = 8'(CalcTimeout);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitCalc,
        StLatch,
        StDraw,
        StNext,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] col_q, col_d;
    logic [7:0] wait_q, wait_d;
    logic [6:0] h_raw_q, h_raw_d;
    logic [6:0] top_q, top_d;
    logic [6:0] bot_q, bot_d;
    logic [6:0] row_q, row_d;
    logic [6:0] h_clamp;

    logic       begin_calc_q, begin_calc_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;

    assign h_clamp = (h_raw_q > MaxH) ? MaxH : h_raw_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        wait_d  = wait_q;
        h_raw_d = h_raw_q;
        top_d   = top_q;
        bot_d   = bot_q;
        row_d   = row_q;

        unique case (state_q)
            StIdle: begin
                col_d = 8'd0;
                if (start_frame) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                wait_d  = 8'd0;
                state_d = StWaitCalc;
            end
            StWaitCalc: begin
                // First cycle ignores end_calc: it may still be high from the previous column.
                if (wait_q == 8'd0) begin
                    wait_d = 8'd1;
                end else if (end_calc) begin
                    h_raw_d = slice_size;
                    state_d = StLatch;
                end else if (wait_q == TimeoutCnt) begin
                    h_raw_d = 7'd0;
                    state_d = StLatch;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StLatch: begin
                // Odd leftover row goes to the floor because the shift rounds top down.
                top_d   = 7'(({1'b0, MaxH} - {1'b0, h_clamp}) >> 1);
                bot_d   = top_d + h_clamp;
                row_d   = 7'd0;
                state_d = StDraw;
            end
            StDraw: begin
                if (row_q == LastRow) begin
                    state_d = StNext;
                end else begin
                    row_d = row_q + 7'd1;
                end
            end
            StNext: begin
                if (col_q == LastCol) begin
                    state_d = StDone;
                end else begin
                    col_d   = col_q + 8'd1;
                    state_d = StStart;
                end
            end
            StDone: begin
                col_d   = 8'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the current state and registered, so they lag it by a cycle.
    always_comb begin
        begin_calc_d = (state_q == StStart);
        busy_d       = (state_q != StIdle);
        plot_d       = (state_q == StDraw);
        frame_done_d = (state_q == StDone);
        x_d          = 8'd0;
        y_d          = 7'd0;
        colour_d     = 3'b000;
        if (state_q == StDraw) begin
            x_d = col_q;
            y_d = row_q;
            if (row_q < top_q) begin
                colour_d = CeilColour;
            end else if (row_q < bot_q) begin
                colour_d = WallColour;
            end else begin
                colour_d = FloorColour;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= StIdle;
            col_q        <= 8'd0;
            wait_q       <= 8'd0;
            h_raw_q      <= 7'd0;
            top_q        <= 7'd0;
            bot_q        <= 7'd0;
            row_q        <= 7'd0;
            begin_calc_q <= 1'b0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            colour_q     <= 3'b000;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            wait_q       <= wait_d;
            h_raw_q      <= h_raw_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
            row_q        <= row_d;
            begin_calc_q <= begin_calc_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign begin_calc   = begin_calc_q;
    assign column_count = col_q;
    assign x            = x_q;
    assign y            = y_q;
    assign colour       = colour_q;
    assign plot         = plot_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_slice_column_renderer.sv
// Randomised bench for slice_column_renderer: a slice-calculator model answers each
// begin_calc and every plotted pixel is checked against the ceiling/wall/floor rule.
module tb_slice_column_renderer;

    localparam int ModeNormal  = 0;
    localparam int ModeStale   = 1;
    localparam int ModeTimeout = 2;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start_frame;
    logic [6:0] slice_size = 7'd0;
    logic       end_calc = 1'b0;
    logic       begin_calc;
    logic [7:0] column_count;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       frame_done;

    always #5 clock = ~clock;

    slice_column_renderer dut (
        .clock       (clock),
        .resetn      (resetn),
        .start_frame (start_frame),
        .slice_size  (slice_size),
        .end_calc    (end_calc),
        .begin_calc  (begin_calc),
        .column_count(column_count),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected colour straight from the height/centring rule.
    function automatic logic [2:0] ref_colour(input int s, input int row);
        int h;
        int top;
        h   = (s > 120) ? 120 : s;
        top = (120 - h) / 2;
        if (row < top) return 3'b001;
        if (row < top + h) return 3'b100;
        return 3'b010;
    endfunction

    function automatic int pick_slice(input int k);
        case (k)
            0: return 40;
            1: return 127;
            2: return 0;
            3: return 41;
            4: return 120;
            5: return 119;
            6: return 1;
            default: return int'($urandom_range(0, 127));
        endcase
    endfunction

    // Written only by the main sequence.
    int mode        = ModeNormal;
    int stale_val   = 60;
    int reset_epoch = 0;

    // Written only by the model/monitor process.
    int   cyc = 0, seen_epoch = 0;
    int   cur_h = 0, cur_lat = 0, cur_bc = 0, cur_mode = ModeNormal;
    int   countdown = 0, post_cnt = 0;
    int   ex_col = 0, ex_row = 0, bc_in_frame = 0;
    int   n_plot = 0, n_bc = 0, n_fd = 0;
    logic prev_bc = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (seen_epoch != reset_epoch) begin
            seen_epoch  = reset_epoch;
            ex_col      = 0;
            ex_row      = 0;
            bc_in_frame = 0;
            countdown   = 0;
            post_cnt    = 0;
            prev_bc     = 1'b0;
        end
        if (mode == ModeStale) begin
            end_calc   = 1'b1;
            slice_size = 7'(stale_val);
        end

        if (begin_calc === 1'b1) begin
            check("begin_calc_single_cycle", prev_bc, 0);
            n_bc++;
            cur_bc   = cyc;
            cur_mode = mode;
            case (mode)
                ModeTimeout: begin
                    cur_h    = 0;
                    cur_lat  = 258;
                    end_calc = 1'b0;
                end
                ModeStale: begin
                    cur_h   = stale_val;
                    cur_lat = 4;
                end
                default: begin
                    cur_h     = pick_slice(bc_in_frame);
                    cur_lat   = 0;
                    end_calc  = 1'b0;
                    countdown = int'($urandom_range(1, 5));
                end
            endcase
            bc_in_frame++;
        end else if (countdown > 0) begin
            countdown--;
            if (countdown == 0) begin
                end_calc   = 1'b1;
                slice_size = 7'(cur_h);
                post_cnt   = 1;
            end
        end else if (post_cnt > 0) begin
            // Value changes after acceptance must not reach the column.
            post_cnt   = 0;
            slice_size = 7'($urandom);
        end
        if (cur_mode == ModeTimeout && end_calc == 1'b0) begin
            slice_size = 7'($urandom);
        end
        prev_bc = begin_calc;

        if (plot === 1'b1) begin
            n_plot++;
            if (ex_row == 0 && cur_lat != 0) begin
                check("calc_to_plot_latency", cyc - cur_bc, cur_lat);
            end
            check("x", x, ex_col);
            check("y", y, ex_row);
            check("colour", colour, ref_colour(cur_h, ex_row));
            ex_row++;
            if (ex_row == 120) begin
                ex_row = 0;
                ex_col++;
            end
        end
        if (frame_done === 1'b1) begin
            n_fd++;
            check("columns_at_frame_done", ex_col, 160);
            ex_col      = 0;
            bc_in_frame = 0;
        end
    end

    task automatic start_and_check();
        start_frame = 1'b1;
        @(negedge clock);
        start_frame = 1'b0;
        check("busy_one_after_start", busy, 0);
        check("begin_calc_one_after_start", begin_calc, 0);
        @(negedge clock);
        check("busy_two_after_start", busy, 1);
        check("begin_calc_two_after_start", begin_calc, 1);
    endtask

    task automatic wait_pix(input int col, input int row, input int budget);
        int n;
        n = 0;
        while (!(plot === 1'b1 && x == 8'(col) && y == 7'(row)) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("reached_pixel_in_budget", (n < budget), 1);
    endtask

    task automatic wait_frame_done(input int budget);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("frame_done_in_budget", (n < budget), 1);
        check("busy_with_frame_done", busy, 1);
        @(negedge clock);
        check("busy_after_frame_done", busy, 0);
        check("frame_done_one_cycle", frame_done, 0);
        check("column_count_after_frame", column_count, 0);
    endtask

    int p0, b0, f0;

    initial begin
        resetn      = 1'b0;
        start_frame = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_begin_calc", begin_calc, 0);
        check("rst_column_count", column_count, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // Frame A: boundary heights then random, with an ignored start_frame at column 20.
        p0 = n_plot; b0 = n_bc; f0 = n_fd;
        start_and_check();
        wait_pix(20, 0, 5000);
        start_frame = 1'b1;
        @(negedge clock);
        start_frame = 1'b0;
        wait_frame_done(40000);
        repeat (5) @(negedge clock);
        check("frame_a_plots", n_plot - p0, 19200);
        check("frame_a_begin_calcs", n_bc - b0, 160);
        check("frame_a_frame_dones", n_fd - f0, 1);
        check("frame_a_idle", busy, 0);

        // Frame B: end_calc stuck high, then reset in the middle of column 50.
        mode = ModeStale;
        repeat (2) @(negedge clock);
        start_and_check();
        wait_pix(50, 30, 10000);
        resetn = 1'b0;
        @(negedge clock);
        check("mid_reset_plot", plot, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_column_count", column_count, 0);
        check("mid_reset_begin_calc", begin_calc, 0);
        resetn = 1'b1;
        mode   = ModeNormal;
        reset_epoch++;
        repeat (3) @(negedge clock);

        // Frame C: first columns time out, the rest answer normally.
        mode = ModeTimeout;
        repeat (2) @(negedge clock);
        p0 = n_plot; b0 = n_bc; f0 = n_fd;
        start_and_check();
        wait_pix(2, 0, 2000);
        mode = ModeNormal;
        wait_frame_done(40000);
        repeat (5) @(negedge clock);
        check("frame_c_plots", n_plot - p0, 19200);
        check("frame_c_begin_calcs", n_bc - b0, 160);
        check("frame_c_frame_dones", n_fd - f0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/slice_column_renderer.md
# slice_column_renderer

Frame-level sequencer and column painter downstream of `find_slice_height`. For each of 160 screen columns it drives `column_count`, pulses `begin_calc`, and waits for `end_calc`, then latches `slice_size`. It then emits one vertical column of 120 pixels (ceiling / wall / floor) to the VGA adapter plot interface, one pixel per clock. After column 159 it pulses `frame_done`.

## Interface
- SCREEN_W, 160, columns per frame; `column_count`/`x` run 0..SCREEN_W-1
- SCREEN_H, 120, rows per column; `y` runs 0..SCREEN_H-1
- CALC_TIMEOUT, 255, max cycles waited for `end_calc` before forcing height 0
- CEIL_COLOUR, 3'b001, colour above the wall slice
- WALL_COLOUR, 3'b100, colour of the wall slice
- FLOOR_COLOUR, 3'b010, colour below the wall slice
- clock  in  1  system clock; all state changes on rising edge
- resetn  in  1  reset, synchronous, active-low
- start_frame  in  1  single-cycle request to render a frame; honoured only in S_IDLE
- slice_size  in  7  projected wall height from `find_slice_height`, unsigned 0..127
- end_calc  in  1  level from `find_slice_height`; slice_size valid while high
- begin_calc  out  1  one-cycle start pulse to `find_slice_height`
- column_count  out  8  current column index, held stable from S_START until S_NEXT
- x  out  8  plot column (equals column_count during S_DRAW)
- y  out  7  plot row
- colour  out  3  plot colour
- plot  out  1  pixel write strobe; x/y/colour valid when high
- busy  out  1  high in every state except S_IDLE
- frame_done  out  1  one-cycle pulse after the last pixel of column SCREEN_W-1

## Operation
- States: S_IDLE, S_START, S_WAIT_CALC, S_LATCH, S_DRAW, S_NEXT, S_DONE. Moore outputs are registered.
- S_IDLE: column_count=0. start_frame=1 -> S_START.
- S_START: begin_calc=1 for exactly this cycle -> S_WAIT_CALC. Wait counter clears to 0.
- S_WAIT_CALC: end_calc is ignored in the first cycle (stale-level guard).
  - From the 2nd cycle on, end_calc=1 -> h_raw<=slice_size, go to S_LATCH.
  - Counter reaching CALC_TIMEOUT -> h_raw<=0, go to S_LATCH.
- S_LATCH:
  - h=min(h_raw, SCREEN_H).
  - top=(SCREEN_H-h)>>1, computed in 8-bit unsigned arithmetic; odd remainder goes to the floor.
  - bottom=top+h.
  - row counter<=0; go to S_DRAW.
- S_DRAW: one pixel per cycle, plot=1, x=column_count, y=row.
  - colour = CEIL_COLOUR if row<top; WALL_COLOUR if top<=row<bottom; FLOOR_COLOUR otherwise.
  - After row SCREEN_H-1 -> S_NEXT.
- S_NEXT:
  - column_count=SCREEN_W-1 -> S_DONE.
  - Otherwise column_count+1 -> S_START.
- S_DONE: frame_done=1 for one cycle, column_count<=0 -> S_IDLE.
- start_frame while busy is ignored; no queuing.
- Reset mid-operation: the next edge forces S_IDLE. All outputs take reset values; the partial frame is abandoned.

## Timing
- Reset values: begin_calc 0, column_count 0, x 0, y 0, colour 0, plot 0, busy 0, frame_done 0.
- start_frame sampled at edge N -> busy=1 and begin_calc=1 after edge N+1.
- begin_calc is never high for 2 consecutive cycles.
- end_calc accepted at edge E -> first plot is visible after edge E+2 (LATCH, then DRAW).
- Per-column cycles = 1 (START) + W (wait, W>=2 or CALC_TIMEOUT+1) + 1 (LATCH) + SCREEN_H (DRAW) + 1 (NEXT).
- plot is high for exactly SCREEN_H consecutive cycles per column, SCREEN_W*SCREEN_H per frame.
- frame_done rises the cycle after S_NEXT of the last column; busy falls one cycle after frame_done.
- slice_size is sampled only on the accepting edge; later changes do not affect the column.

## Test plan
- Slice model returns end_calc 3 cycles after begin_calc with slice_size=40 for every column -> each column: y0-39 CEIL, y40-79 WALL, y80-119 FLOOR. Totals: 19200 plots, 160 begin_calc pulses, one frame_done.
- slice_size=127 -> clamped to 120, all 120 rows WALL. slice_size=0 -> all rows CEIL (y0-59) or FLOOR (y60-119), no WALL.
- slice_size=41 -> top=39, bottom=80: y39 WALL, y80 FLOOR, y38 CEIL.
- end_calc held high from before begin_calc and through the first S_WAIT_CALC cycle -> not accepted in that first cycle; accepted on the 2nd. end_calc never asserted -> after CALC_TIMEOUT cycles the column draws with h=0 and the frame continues to column 159.
- start_frame pulsed at column 20 mid-frame -> ignored, frame completes normally with a single frame_done.
- resetn=0 during S_DRAW of column 50, row 30 -> the next cycle shows plot=0, busy=0, column_count=0. A new start_frame renders from column 0.
